// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the combinational ROM (slave).
interface fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rd_i;

  modport master (output imem_addr_o, input imem_rd_i);
  modport slave  (input imem_addr_o, output imem_rd_i);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the ROM and fills the IF/ID register.
// A PC outside the ROM window or misaligned parks the stage in a sticky FAULT state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] ROM_BASE  = 32'hBFC00000,
  parameter int          ROM_BYTES = 4096,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_d_o,
  output logic [31:0]          pc_d_o,
  output logic [31:0]          pc_plus4_d_o,
  output logic                 valid_d_o,
  output logic                 fault_o,
  output logic [31:0]          fault_pc_o,
  output logic [31:0]          fetch_count_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  localparam logic [31:0] ROM_LAST = ROM_BASE + 32'(ROM_BYTES) - 32'd4;

  function automatic logic pc_is_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < ROM_BASE) || (pc > ROM_LAST);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4_s;
  logic        pc_bad_s;

  assign pc_plus4_s = pc_q + 32'd4;
  assign pc_bad_s   = pc_is_bad(pc_q);

  // Next-state, next-PC and IF/ID selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_pc4_d = ifid_pc4_q;
    valid_d    = valid_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    case (state_q)
      ST_RUN: begin
        if (pc_bad_s) begin
          // PC stays on the offending address so it remains visible on the bus.
          state_d    = ST_FAULT;
          fault_pc_d = pc_q;
          instr_d    = NOP_INSTR;
          ifid_pc_d  = 32'd0;
          ifid_pc4_d = 32'd0;
          valid_d    = 1'b0;
        end else begin
          if (redirect_i) begin
            pc_d = redirect_pc_i;
          end else if (stall_i) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_plus4_s;
          end

          if (flush_i || redirect_i) begin
            instr_d    = NOP_INSTR;
            ifid_pc_d  = 32'd0;
            ifid_pc4_d = 32'd0;
            valid_d    = 1'b0;
          end else if (stall_i) begin
            instr_d    = instr_q;
            ifid_pc_d  = ifid_pc_q;
            ifid_pc4_d = ifid_pc4_q;
            valid_d    = valid_q;
          end else begin
            instr_d    = imem.imem_rd_i;
            ifid_pc_d  = pc_q;
            ifid_pc4_d = pc_plus4_s;
            valid_d    = 1'b1;
            count_d    = count_q + 32'd1;
          end
        end
      end
      ST_FAULT: begin
        pc_d       = pc_q;
        instr_d    = NOP_INSTR;
        ifid_pc_d  = 32'd0;
        ifid_pc4_d = 32'd0;
        valid_d    = 1'b0;
      end
      default: begin
        state_d    = ST_FAULT;
        fault_pc_d = pc_q;
        instr_d    = NOP_INSTR;
        ifid_pc_d  = 32'd0;
        ifid_pc4_d = 32'd0;
        valid_d    = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      ifid_pc_q  <= 32'd0;
      ifid_pc4_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      valid_q    <= valid_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem.imem_addr_o = pc_q;
  assign instr_d_o        = instr_q;
  assign pc_d_o           = ifid_pc_q;
  assign pc_plus4_d_o     = ifid_pc4_q;
  assign valid_d_o        = valid_q;
  assign fault_o          = (state_q == ST_FAULT);
  assign fault_pc_o       = fault_pc_q;
  assign fetch_count_o    = count_q;

endmodule
